// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares the single-port data memory between the pipeline
// memory stage and a loader/debug port.
//
// Pipeline has priority. A loader that has been blocked for MAX_WAIT cycles
// is forced through, and the pipeline is stalled for that one cycle. Every
// loader access is followed by one S_ACK cycle. In that cycle ld_ack pulses
// and the loader cannot be granted, so the loader gets at most one access
// every two cycles.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   MemReqM/MemWriteM    pipeline request / store flag
//   AddrM/WriteDataM     pipeline address / store data
//   ReadDataM, StallM    pipeline load data (combinational) / hold M stage
//   ld_req/ld_we         loader request / write flag (held until ld_ack)
//   ld_addr/ld_wdata     loader address / write data
//   ld_ack, ld_rdata     loader completion pulse / registered read data
//   WE/WA/WD, DataRD     memory write enable, address, write data, read data
//   stat_ld_grants       loader grant count (stats build)
//   stat_stalls          forced-stall cycle count (stats build)
//
// Build option: define DMEM_ARB_STATS_EN to add the two saturating 16-bit
// statistics counters. Without it, both stat outputs are tied to 0.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CW       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_ack,
  output logic [31:0] ld_rdata,
  output logic        WE,
  output logic [31:0] WA,
  output logic [31:0] WD,
  input  logic [31:0] DataRD,
  output logic [15:0] stat_ld_grants,
  output logic [15:0] stat_stalls
);

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_e;

  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   ld_rdata_q, ld_rdata_d;

  logic idle, force_ld, ld_grant, pipe_grant;

  assign idle       = (state_q == S_IDLE);
  assign force_ld   = ld_req & (wait_cnt_q == WAIT_MAX) & idle;
  assign ld_grant   = idle & ld_req & (~MemReqM | force_ld);
  assign pipe_grant = MemReqM & ~force_ld;

  // Memory-side routing. The read data goes straight back to the pipeline.
  // ReadDataM is only meaningful while the pipeline is granted.
  always_comb begin
    WE        = 1'b0;
    WA        = AddrM;
    WD        = WriteDataM;
    StallM    = 1'b0;
    ReadDataM = DataRD;
    if (ld_grant) begin
      WE     = ld_we;
      WA     = ld_addr;
      WD     = ld_wdata;
      StallM = MemReqM;
    end else if (pipe_grant) begin
      WE = MemWriteM;
    end
    // Reset overrides everything so nothing is written while rst is high.
    if (rst) begin
      WE     = 1'b0;
      StallM = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ld_rdata_d = ld_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (ld_grant) begin
          // Writes capture DataRD as well; the value is harmless.
          ld_rdata_d = DataRD;
          wait_cnt_d = '0;
          state_d    = S_ACK;
        end else if (ld_req && wait_cnt_q != WAIT_MAX) begin
          // The loader is blocked by the pipeline this cycle.
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      ld_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ld_rdata_q <= ld_rdata_d;
    end
  end

  assign ld_ack   = (state_q == S_ACK) & ~rst;
  assign ld_rdata = ld_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] grants_q, grants_d, stalls_q, stalls_d;

  always_comb begin
    grants_d = grants_q;
    stalls_d = stalls_q;
    if (ld_grant && grants_q != 16'hFFFF) grants_d = grants_q + 16'd1;
    if (StallM   && stalls_q != 16'hFFFF) stalls_d = stalls_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      grants_q <= grants_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_ld_grants = grants_q;
  assign stat_stalls    = stalls_q;
`else
  assign stat_ld_grants = '0;
  assign stat_stalls    = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. It includes a small behavioural data
// memory. Expected loader read data is queued when a grant is issued. A
// negedge monitor pops the queue on every ld_ack and checks ld_rdata.
// Combinational routing is checked directly in the stimulus process.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        MemReqM, MemWriteM;
  logic [31:0] AddrM, WriteDataM, ReadDataM;
  logic        StallM;
  logic        ld_req, ld_we;
  logic [31:0] ld_addr, ld_wdata;
  logic        ld_ack;
  logic [31:0] ld_rdata;
  logic        WE;
  logic [31:0] WA, WD, DataRD;
  logic [15:0] stat_ld_grants, stat_stalls;

  int checks = 0;
  int fails  = 0;
  logic [31:0] sb_q[$];

  bit [31:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) if (WE) mem[WA[9:2]] <= WD;
  assign DataRD = mem[WA[9:2]];

  dmem_arbiter #(.MAX_WAIT(4), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .MemReqM(MemReqM), .MemWriteM(MemWriteM), .AddrM(AddrM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .WE(WE), .WA(WA), .WD(WD), .DataRD(DataRD),
    .stat_ld_grants(stat_ld_grants), .stat_stalls(stat_stalls)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && ld_ack) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL ld_ack_unexpected got=ack expected=no_ack t=%0t", $time);
      end else begin
        chk("ld_rdata", ld_rdata, sb_q.pop_front());
      end
    end
  end

  // Pipeline loads 0x10 continuously. The loader reads 0x80 and is blocked
  // for 4 cycles, then forced through with a one-cycle stall.
  task automatic forced_read();
    MemReqM = 1; MemWriteM = 0; AddrM = 32'h10;
    ld_req = 1; ld_we = 0; ld_addr = 32'h80;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("blk_stall", {31'd0, StallM}, 32'd0);
      chk("blk_wa", WA, 32'h10);
      chk("blk_rd", ReadDataM, 32'hA5);
      step();
    end
    #3;
    chk("force_stall", {31'd0, StallM}, 32'd1);
    chk("force_wa", WA, 32'h80);
    chk("force_we", {31'd0, WE}, 32'd0);
    sb_q.push_back(32'h12345678);
    step();
    ld_req = 0;
    #3;
    chk("ack_pipe_stall", {31'd0, StallM}, 32'd0);
    chk("ack_pipe_wa", WA, 32'h10);
    step();
    MemReqM = 0;
  endtask

  initial begin
    rst = 1; MemReqM = 0; MemWriteM = 0; AddrM = 0; WriteDataM = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    step(); step();
    chk("rst_we", {31'd0, WE}, 32'd0);
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_ack", {31'd0, ld_ack}, 32'd0);
    chk("rst_rdata", ld_rdata, 32'd0);
    chk("rst_stat_g", {16'd0, stat_ld_grants}, 32'd0);
    chk("rst_stat_s", {16'd0, stat_stalls}, 32'd0);
    rst = 0;
    step();

    // Uncontended loader write.
    ld_req = 1; ld_we = 1; ld_addr = 32'h40; ld_wdata = 32'hDEADBEEF;
    #3;
    chk("t1_we", {31'd0, WE}, 32'd1);
    chk("t1_wa", WA, 32'h40);
    chk("t1_wd", WD, 32'hDEADBEEF);
    chk("t1_stall", {31'd0, StallM}, 32'd0);
    sb_q.push_back(32'h0);
    step();
    ld_req = 0;
    #3;
    chk("t1_ack_we", {31'd0, WE}, 32'd0);
    step();

    // Read the word back through the loader.
    ld_req = 1; ld_we = 0;
    sb_q.push_back(32'hDEADBEEF);
    step();
    ld_req = 0;
    step();

    // Preload: pipeline store 0x10=0xA5, loader write 0x80=0x12345678.
    MemReqM = 1; MemWriteM = 1; AddrM = 32'h10; WriteDataM = 32'hA5;
    #3;
    chk("pst_we", {31'd0, WE}, 32'd1);
    chk("pst_wa", WA, 32'h10);
    step();
    MemReqM = 0; MemWriteM = 0;
    ld_req = 1; ld_we = 1; ld_addr = 32'h80; ld_wdata = 32'h12345678;
    sb_q.push_back(32'h0);
    step();
    ld_req = 0;
    step();

    // Clear the stats, then run the forced-grant scenario three times.
    rst = 1; step(); rst = 0; step();
    forced_read();
    forced_read();
    forced_read();
`ifdef DMEM_ARB_STATS_EN
    chk("stat_grants", {16'd0, stat_ld_grants}, 32'd3);
    chk("stat_stalls", {16'd0, stat_stalls}, 32'd3);
`else
    chk("stat_grants", {16'd0, stat_ld_grants}, 32'd0);
    chk("stat_stalls", {16'd0, stat_stalls}, 32'd0);
`endif

    // Back-to-back loader requests with the pipeline idle.
    ld_req = 1; ld_we = 0; ld_addr = 32'h40;
    #3;
    chk("b2b_n_wa", WA, 32'h40);
    sb_q.push_back(32'hDEADBEEF);
    step();
    ld_we = 1; ld_addr = 32'h80; ld_wdata = 32'h55;
    AddrM = 32'h20;
    #3;
    chk("b2b_ack_we", {31'd0, WE}, 32'd0);
    chk("b2b_ack_wa", WA, 32'h20);
    step();
    #3;
    chk("b2b_n2_we", {31'd0, WE}, 32'd1);
    chk("b2b_n2_wa", WA, 32'h80);
    sb_q.push_back(32'h12345678);
    step();
    ld_req = 0;
    step();

    // Reset pulsed during S_ACK: the ack is lost and the request is re-served.
    ld_req = 1; ld_we = 1; ld_addr = 32'h44; ld_wdata = 32'h77;
    #3;
    chk("r5_we", {31'd0, WE}, 32'd1);
    step();
    rst = 1;
    #1;
    chk("r5_ack", {31'd0, ld_ack}, 32'd0);
    chk("r5_we_rst", {31'd0, WE}, 32'd0);
    step();
    rst = 0;
    #3;
    chk("r5_regrant_we", {31'd0, WE}, 32'd1);
    chk("r5_regrant_wa", WA, 32'h44);
    sb_q.push_back(32'h77);
    step();
    ld_req = 0;
    step(); step();

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
